// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data-memory load/store unit with byte-masked word port and fault checks
// Optional word-crossing split: define LSU_MISALIGN_SPLIT_EN to enable the second (ACC1) beat.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h1000_0000,
  parameter int unsigned DMEM_SIZE = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [1:0] S_ACC1 = 2'd2;
`endif
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [32:0] LIMIT = {1'b0, DMEM_BASE} + 33'(DMEM_SIZE);

  function automatic logic [2:0] size_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // d holds {hi, lo}; the addressed bytes are shifted down to lane 0 before extension
  function automatic logic [31:0] extend(input logic [63:0] d, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = 32'(d >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b01:   return f3[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [2:0]  n_in;
  logic [32:0] last_in;
  logic        illegal;
  logic        out_of_range;
  logic        fault;

  assign n_in         = size_of(funct3_i[1:0]);
  assign last_in      = {1'b0, addr_i} + {30'b0, n_in} - 33'd1;
  assign illegal      = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110) || (we_i && funct3_i[2]);
  assign out_of_range = (addr_i < DMEM_BASE) || (last_in >= LIMIT);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign fault = illegal || out_of_range;
`else
  assign fault = illegal || out_of_range || (({1'b0, addr_i[1:0]} + n_in) > 3'd4);
`endif

  logic [2:0]  n_q;
  logic [1:0]  off_q;
  logic [3:0]  lanes;
  logic [31:0] word_q;

  assign n_q    = size_of(f3_q[1:0]);
  assign off_q  = addr_q[1:0];
  assign word_q = {addr_q[31:2], 2'b00};
  assign lanes  = (n_q == 3'd1) ? 4'b0001 : (n_q == 3'd2) ? 4'b0011 : 4'b1111;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [6:0]  mask_w;
  logic [63:0] wdata_w;
  logic        crosses;
  logic [31:0] lo_q;

  assign mask_w  = {3'b000, lanes} << off_q;
  assign wdata_w = {32'b0, wdata_q} << {off_q, 3'b000};
  assign crosses = ({1'b0, off_q} + n_q) > 3'd4;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q    <= 32'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_i) begin
          we_q    <= we_i;
          f3_q    <= funct3_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          err_q   <= fault;
          state   <= fault ? S_RESP : S_ACC0;
        end
        S_ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (!we_q) lo_q <= mem_rdata_i;
          if (crosses) begin
            state <= S_ACC1;
          end else begin
            state <= S_RESP;
            if (!we_q) rdata_q <= extend({32'b0, mem_rdata_i}, off_q, f3_q);
          end
`else
          state <= S_RESP;
          if (!we_q) rdata_q <= extend({32'b0, mem_rdata_i}, off_q, f3_q);
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_ACC1: begin
          state <= S_RESP;
          if (!we_q) rdata_q <= extend({mem_rdata_i, lo_q}, off_q, f3_q);
        end
`endif
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state == S_IDLE);
  assign done_o  = (state == S_RESP);
  assign err_o   = done_o && err_q;
  assign rdata_o = rdata_q;

  // Memory port is idle outside the access beats so IDLE/RESP can never write
  always_comb begin
    mem_we_o    = 1'b0;
    mem_wmask_o = 4'b0;
    mem_addr_o  = 32'b0;
    mem_wdata_o = 32'b0;
    case (state)
      S_ACC0: begin
        mem_we_o    = we_q;
        mem_addr_o  = word_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        mem_wmask_o = mask_w[3:0];
        mem_wdata_o = wdata_w[31:0];
`else
        mem_wmask_o = lanes << off_q;
        mem_wdata_o = wdata_q << {off_q, 3'b000};
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACC1: begin
        mem_we_o    = we_q;
        mem_addr_o  = word_q + 32'd4;
        mem_wmask_o = {1'b0, mask_w[6:4]};
        mem_wdata_o = wdata_w[63:32];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with byte-level memory model
module tb_dmem_lsu;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int SIZE = 16384;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, req_i, we_i;
  logic [2:0] funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic ready_o, done_o, err_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_wmask_o;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  logic [7:0] mem_b [SIZE];
  logic [7:0] model_b [SIZE];
  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    logic [31:0] o;
    o = mem_addr_o - BASE;
    mem_rdata_i = 32'b0;
    if (mem_addr_o >= BASE && o < SIZE)
      mem_rdata_i = {mem_b[o+3], mem_b[o+2], mem_b[o+1], mem_b[o]};
  end

  // Writes are applied at the sample point just before the edge that would commit them
  task automatic apply_write();
    logic [31:0] o;
    o = mem_addr_o - BASE;
    if (mem_we_o && mem_addr_o >= BASE && o < SIZE)
      for (int k = 0; k < 4; k++)
        if (mem_wmask_o[k]) mem_b[o+k] = mem_wdata_o[8*k +: 8];
  endtask

  int r_lat, r_nbeat, r_nwr;
  logic r_done, r_err;
  logic [31:0] r_rdata;
  logic [31:0] b_addr [4];
  logic [31:0] b_wdata [4];
  logic [3:0] b_mask [4];
  logic b_we [4];
  logic [31:0] exp_last;
  logic last_known;

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = w; funct3_i = f3; addr_i = a; wdata_i = d;
    @(posedge clk);
    #1 req_i = 1'b0;
    r_lat = 0; r_nbeat = 0; r_nwr = 0; r_done = 1'b0; r_err = 1'b0; r_rdata = 32'b0;
    for (int c = 1; c <= 8 && !r_done; c++) begin
      @(negedge clk);
      if (mem_we_o) r_nwr++;
      if (mem_wmask_o != 4'b0 && r_nbeat < 4) begin
        b_addr[r_nbeat] = mem_addr_o; b_mask[r_nbeat] = mem_wmask_o;
        b_wdata[r_nbeat] = mem_wdata_o; b_we[r_nbeat] = mem_we_o;
        r_nbeat++;
      end
      apply_write();
      if (done_o) begin
        r_done = 1'b1; r_lat = c; r_err = err_o; r_rdata = rdata_o;
      end
    end
  endtask

  function automatic int size_n(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic [63:0] a64;
    int n;
    n = size_n(f3);
    a64 = {32'b0, a};
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && f3 >= 3'd4)) return 1'b1;
    if (a64 < 64'(BASE) || a64 + 64'(n) - 64'd1 >= 64'(BASE) + 64'(SIZE)) return 1'b1;
    if (!SPLIT && (int'(a[1:0]) + n > 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v, o;
    int n;
    n = size_n(f3);
    o = a - BASE;
    v = 32'b0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = model_b[o+k];
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o;
    o = a - BASE;
    for (int k = 0; k < size_n(f3); k++) model_b[o+k] = d[8*k +: 8];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_cmp++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got %b%b want 00", done_o, err_o); end
    n_cmp++; if (rdata_o !== 32'b0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    n_cmp++; if ({mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !== 69'b0) begin n_bad++; $display("FAIL reset_mem got we=%b m=%b a=%h d=%h want all 0", mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o); end
    rst_n = 1'b1;
    exp_last = 32'b0; last_known = 1'b1;
  endtask

  task automatic test_aligned();
    run_req(1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF);
    model_store(3'b010, 32'h1000_0008, 32'hDEAD_BEEF);
    n_cmp++; if (r_lat !== 2 || r_err !== 1'b0) begin n_bad++; $display("FAIL sw_lat_err got lat=%0d err=%b want 2/0", r_lat, r_err); end
    n_cmp++; if (r_nbeat !== 1 || r_nwr !== 1) begin n_bad++; $display("FAIL sw_beats got %0d/%0d want 1/1", r_nbeat, r_nwr); end
    n_cmp++; if (b_addr[0] !== 32'h1000_0008 || b_mask[0] !== 4'b1111 || b_we[0] !== 1'b1 || b_wdata[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_beat got a=%h m=%b we=%b d=%h want 10000008/1111/1/deadbeef", b_addr[0], b_mask[0], b_we[0], b_wdata[0]); end
    run_req(1'b1, 3'b010, 32'h1000_0004, 32'h0000_8000);
    model_store(3'b010, 32'h1000_0004, 32'h0000_8000);
    run_req(1'b0, 3'b000, 32'h1000_0005, 32'h0);
    n_cmp++; if (r_rdata !== 32'hFFFF_FF80 || r_lat !== 2) begin n_bad++; $display("FAIL lb got %h lat=%0d want ffffff80/2", r_rdata, r_lat); end
    run_req(1'b0, 3'b100, 32'h1000_0005, 32'h0);
    n_cmp++; if (r_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu got %h want 00000080", r_rdata); end
    run_req(1'b0, 3'b101, 32'h1000_0004, 32'h0);
    n_cmp++; if (r_rdata !== 32'h0000_8000 || r_nwr !== 0) begin n_bad++; $display("FAIL lhu got %h wr=%0d want 00008000/0", r_rdata, r_nwr); end
    exp_last = 32'h0000_8000;
    run_req(1'b1, 3'b000, 32'h1000_0013, 32'h0000_00AB);
    model_store(3'b000, 32'h1000_0013, 32'h0000_00AB);
    n_cmp++; if (b_addr[0] !== 32'h1000_0010 || b_mask[0] !== 4'b1000 || b_wdata[0] !== 32'hAB00_0000) begin n_bad++; $display("FAIL sb_beat got a=%h m=%b d=%h want 10000010/1000/ab000000", b_addr[0], b_mask[0], b_wdata[0]); end
    n_cmp++; if (r_rdata !== exp_last) begin n_bad++; $display("FAIL sb_hold got %h want %h", r_rdata, exp_last); end
  endtask

  task automatic test_split();
    run_req(1'b1, 3'b010, 32'h1000_0020, 32'h4433_2211);
    model_store(3'b010, 32'h1000_0020, 32'h4433_2211);
    run_req(1'b1, 3'b010, 32'h1000_0024, 32'h8877_6655);
    model_store(3'b010, 32'h1000_0024, 32'h8877_6655);
    run_req(1'b0, 3'b010, 32'h1000_0022, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_cmp++; if (r_rdata !== 32'h6655_4433 || r_lat !== 3 || r_err !== 1'b0) begin n_bad++; $display("FAIL lw_split got %h lat=%0d err=%b want 66554433/3/0", r_rdata, r_lat, r_err); end
    n_cmp++; if (r_nbeat !== 2 || b_addr[0] !== 32'h1000_0020 || b_addr[1] !== 32'h1000_0024) begin n_bad++; $display("FAIL lw_split_addr got n=%0d %h %h want 2 10000020 10000024", r_nbeat, b_addr[0], b_addr[1]); end
    exp_last = 32'h6655_4433;
`else
    n_cmp++; if (r_err !== 1'b1 || r_lat !== 1 || r_nbeat !== 0) begin n_bad++; $display("FAIL lw_cross_fault got err=%b lat=%0d beats=%0d want 1/1/0", r_err, r_lat, r_nbeat); end
    last_known = 1'b0;
`endif
    run_req(1'b1, 3'b001, 32'h1000_0023, 32'h0000_BEEF);
`ifdef LSU_MISALIGN_SPLIT_EN
    model_store(3'b001, 32'h1000_0023, 32'h0000_BEEF);
    n_cmp++; if (r_nwr !== 2 || b_mask[0] !== 4'b1000 || b_mask[1] !== 4'b0001) begin n_bad++; $display("FAIL sh_split got wr=%0d m0=%b m1=%b want 2/1000/0001", r_nwr, b_mask[0], b_mask[1]); end
    n_cmp++; if (b_wdata[0][31:24] !== 8'hEF || b_wdata[1][7:0] !== 8'hBE) begin n_bad++; $display("FAIL sh_split_data got %h %h want ef.. ..be", b_wdata[0], b_wdata[1]); end
`else
    n_cmp++; if (r_err !== 1'b1 || r_nwr !== 0) begin n_bad++; $display("FAIL sh_cross_fault got err=%b wr=%0d want 1/0", r_err, r_nwr); end
`endif
  endtask

  task automatic test_faults();
    logic [31:0] fa [4];
    logic [2:0] ff [4];
    logic fw [4];
    fa = '{32'h1000_4000, 32'h0FFF_FFFC, 32'h1000_0040, 32'h1000_0044};
    ff = '{3'b010, 3'b010, 3'b011, 3'b100};
    fw = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_req(fw[i], ff[i], fa[i], 32'h1234_5678);
      n_cmp++; if (r_err !== 1'b1 || r_lat !== 1 || r_nwr !== 0) begin n_bad++; $display("FAIL fault_%0d got err=%b lat=%0d wr=%0d want 1/1/0", i, r_err, r_lat, r_nwr); end
    end
    last_known = 1'b0;
    run_req(1'b0, 3'b010, 32'h1000_3FFC, 32'h0);
    n_cmp++; if (r_err !== 1'b0 || r_rdata !== model_load(3'b010, 32'h1000_3FFC)) begin n_bad++; $display("FAIL lw_top got err=%b %h want 0/%h", r_err, r_rdata, model_load(3'b010, 32'h1000_3FFC)); end
    exp_last = r_rdata; last_known = (r_err === 1'b0);
  endtask

  task automatic test_reset_mid();
    int wr_after, done_after;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h1000_0032; wdata_i = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_cmp++; if (mem_we_o !== 1'b1 || mem_wmask_o !== 4'b1100) begin n_bad++; $display("FAIL mid_acc0 got we=%b m=%b want 1/1100", mem_we_o, mem_wmask_o); end
    model_b[32'h32] = 8'h0D; model_b[32'h33] = 8'hF0;
`endif
    apply_write();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1 || done_o !== 1'b0 || rdata_o !== 32'b0) begin n_bad++; $display("FAIL mid_state got rdy=%b done=%b rd=%h want 1/0/0", ready_o, done_o, rdata_o); end
    n_cmp++; if ({mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !== 69'b0) begin n_bad++; $display("FAIL mid_mem got we=%b m=%b a=%h want all 0", mem_we_o, mem_wmask_o, mem_addr_o); end
    rst_n = 1'b1;
    wr_after = 0; done_after = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_we_o) wr_after++;
      if (done_o) done_after++;
      apply_write();
    end
    n_cmp++; if (wr_after !== 0 || done_after !== 0) begin n_bad++; $display("FAIL mid_after got wr=%0d done=%0d want 0/0", wr_after, done_after); end
    for (int k = 32'h32; k < 32'h36; k++) begin
      n_cmp++; if (mem_b[k] !== model_b[k]) begin n_bad++; $display("FAIL mid_byte_%0h got %h want %h", k, mem_b[k], model_b[k]); end
    end
    exp_last = 32'b0; last_known = 1'b1;
  endtask

  task automatic test_random(input int iters);
    logic [2:0] f3tab [13];
    logic w, ef, cr;
    logic [2:0] f3;
    logic [31:0] a, d, ev;
    int el, ew;
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < iters; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = f3tab[$urandom_range(0, 12)];
      d = $urandom;
      case ($urandom_range(0, 9))
        0: a = BASE - 32'($urandom_range(1, 4));
        1: a = BASE + 32'(SIZE) - 32'($urandom_range(0, 4));
        2: a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      ef = model_fault(w, f3, a);
      cr = (int'(a[1:0]) + size_n(f3)) > 4;
      el = ef ? 1 : (cr ? 3 : 2);
      ew = (ef || !w) ? 0 : (cr ? 2 : 1);
      ev = (!ef && !w) ? model_load(f3, a) : 32'b0;
      run_req(w, f3, a, d);
      n_cmp++; if (r_done !== 1'b1 || r_err !== ef || r_lat !== el) begin n_bad++; $display("FAIL rnd_%0d_resp w=%b f3=%0d a=%h got done=%b err=%b lat=%0d want 1/%b/%0d", i, w, f3, a, r_done, r_err, r_lat, ef, el); end
      n_cmp++; if (r_nwr !== ew) begin n_bad++; $display("FAIL rnd_%0d_writes got %0d want %0d", i, r_nwr, ew); end
      if (!w && !ef) begin
        n_cmp++; if (r_rdata !== ev) begin n_bad++; $display("FAIL rnd_%0d_load f3=%0d a=%h got %h want %h", i, f3, a, r_rdata, ev); end
        exp_last = ev; last_known = 1'b1;
      end else if (w) begin
        if (last_known) begin
          n_cmp++; if (r_rdata !== exp_last) begin n_bad++; $display("FAIL rnd_%0d_hold got %h want %h", i, r_rdata, exp_last); end
        end
        if (!ef) model_store(f3, a, d);
      end else begin
        last_known = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'b0; wdata_i = 32'b0;
    for (int k = 0; k < SIZE; k++) begin
      mem_b[k] = 8'($urandom);
      model_b[k] = mem_b[k];
    end
    test_reset();
    test_aligned();
    test_split();
    test_faults();
    test_reset_mid();
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
